io_port_bank: RTL and testbench

Parametrised memory-mapped GPIO bank for the single-cycle ARM `top`, replacing the fixed 8-bit `port`/`cmp2` pair at 0x800.

- Provides a `WIDTH`-bit input channel with a two-flop synchroniser, per-bit debounce and sticky rising-edge flags.
- Provides a `WIDTH`-bit output register with atomic set and clear writes.
- Provides an interrupt-enable mask and a level interrupt.
- Decodes a 32-byte window at `BASE_ADDR` and returns read data combinationally, so it slots into the existing single-cycle read mux.

---
 rtl/io_port_bank_pkg.sv | 27 ++
 rtl/io_debounce.sv | 66 ++++++
 rtl/io_port_bank.sv | 104 ++++++++++
 tb/tb_io_port_bank.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_bank_pkg.sv
// Register map and address-decode types shared by the io_port_bank files.
package io_port_bank_pkg;

  localparam logic [4:0] OFS_DATA_IN  = 5'h00;
  localparam logic [4:0] OFS_DATA_OUT = 5'h04;
  localparam logic [4:0] OFS_OUT_SET  = 5'h08;
  localparam logic [4:0] OFS_OUT_CLR  = 5'h0C;
  localparam logic [4:0] OFS_EDGE     = 5'h10;
  localparam logic [4:0] OFS_IRQ_EN   = 5'h14;

  // Word index within the 32-byte window, i.e. addr[4:2].
  typedef enum logic [2:0] {
    RegDataIn  = OFS_DATA_IN[4:2],
    RegDataOut = OFS_DATA_OUT[4:2],
    RegOutSet  = OFS_OUT_SET[4:2],
    RegOutClr  = OFS_OUT_CLR[4:2],
    RegEdge    = OFS_EDGE[4:2],
    RegIrqEn   = OFS_IRQ_EN[4:2],
    RegRsvd6   = 3'd6,
    RegRsvd7   = 3'd7
  } io_reg_e;

  function automatic io_reg_e reg_of(input logic [4:0] ofs);
    return io_reg_e'(ofs[4:2]);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One-bit input conditioner: two-flop synchroniser and a stable-value filter.
// The debounce counter exists only when IO_PORT_BANK_DEBOUNCE_EN is defined.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_stable,
  output logic o_rise
);

  logic r_sync1;
  logic r_sync2;
  logic r_stable;
  logic w_stable_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
    end else begin
      r_sync1  <= i_pin;
      r_sync2  <= r_sync1;
      r_stable <= w_stable_d;
    end
  end

`ifdef IO_PORT_BANK_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  // Any sample agreeing with stable restarts the count, so short glitches never land.
  always_comb begin
    w_cnt_d    = '0;
    w_stable_d = r_stable;
    if (r_sync2 != r_stable) begin
      if (r_cnt == CntMax) begin
        w_stable_d = r_sync2;
      end else begin
        w_cnt_d = r_cnt + CntOne;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end
`else
  assign w_stable_d = r_sync2;
`endif

  assign o_stable = r_stable;
  // Rise is flagged on the same edge that stable takes its new value.
  assign o_rise   = w_stable_d & ~r_stable;

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped GPIO bank: debounced inputs with sticky rising-edge flags, set/clear outputs,
// masked level interrupt. Debounce filtering is enabled by IO_PORT_BANK_DEBOUNCE_EN.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter logic [31:0] BASE_ADDR       = 32'h800,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic             sel,
  input  logic [WIDTH-1:0] in_pins,
  output logic [WIDTH-1:0] out_pins,
  output logic             irq
);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_irq_en;

  logic [WIDTH-1:0] w_out_d;
  logic [WIDTH-1:0] w_edge_d;
  logic [WIDTH-1:0] w_irq_en_d;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rd;
  logic             w_wr;
  io_reg_e          w_reg;
  logic             w_unused;

  assign sel      = (addr[31:5] == BASE_ADDR[31:5]);
  assign w_reg    = reg_of(addr[4:0]);
  assign w_wr     = we & sel;
  assign w_wdata  = wdata[WIDTH-1:0];
  assign w_unused = ^{addr[1:0], wdata};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .i_pin   (in_pins[gi]),
      .o_stable(w_stable[gi]),
      .o_rise  (w_rise[gi])
    );
  end

  always_comb begin
    w_out_d    = r_out;
    w_irq_en_d = r_irq_en;
    w_w1c      = '0;
    if (w_wr) begin
      case (w_reg)
        RegDataOut: w_out_d    = w_wdata;
        RegOutSet:  w_out_d    = r_out | w_wdata;
        RegOutClr:  w_out_d    = r_out & ~w_wdata;
        RegEdge:    w_w1c      = w_wdata;
        RegIrqEn:   w_irq_en_d = w_wdata;
        default:    ;
      endcase
    end
    // A new rising edge beats a simultaneous write-one-to-clear.
    w_edge_d = (r_edge & ~w_w1c) | w_rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out    <= '0;
      r_edge   <= '0;
      r_irq_en <= '0;
    end else begin
      r_out    <= w_out_d;
      r_edge   <= w_edge_d;
      r_irq_en <= w_irq_en_d;
    end
  end

  always_comb begin
    w_rd = '0;
    if (sel) begin
      case (w_reg)
        RegDataIn:  w_rd = w_stable;
        RegDataOut: w_rd = r_out;
        RegEdge:    w_rd = r_edge;
        RegIrqEn:   w_rd = r_irq_en;
        default:    w_rd = '0;
      endcase
    end
    rdata            = '0;
    rdata[WIDTH-1:0] = w_rd;
  end

  assign out_pins = r_out;
  assign irq      = |(r_edge & r_irq_en);

endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: directed register-map cases plus randomized traffic.
module tb_io_port_bank;

  localparam int unsigned W    = 8;
  localparam int unsigned DEB  = 4;
  localparam logic [31:0] BASE = 32'h800;
`ifdef IO_PORT_BANK_DEBOUNCE_EN
  localparam int unsigned DEFF = DEB;
`else
  localparam int unsigned DEFF = 1;
`endif
  // Edges from a pin change to the new DATA_IN value.
  localparam int unsigned LAT = DEFF + 2;

  bit clk = 1'b0;
  logic          reset;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          we;
  logic [31:0]   rdata;
  logic          sel;
  logic [W-1:0]  in_pins;
  logic [W-1:0]  out_pins;
  logic          irq;

  always #5 clk = ~clk;

  io_port_bank #(
    .WIDTH          (W),
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(DEB)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .sel     (sel),
    .in_pins (in_pins),
    .out_pins(out_pins),
    .irq     (irq)
  );

  typedef struct packed {
    logic          sel;
    logic [31:0]   rdata;
    logic [W-1:0]  out;
    logic          irq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference state: what the register map says the bank holds.
  logic [W-1:0] m_stable, m_out, m_edge, m_en;
  logic [W-1:0] m_hist[$];  // pin values at recent edges, newest first

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_stable = '0;
    m_out    = '0;
    m_edge   = '0;
    m_en     = '0;
    m_hist.delete();
    for (int i = 0; i < int'(DEFF) + 2; i++) m_hist.push_back('0);
  endfunction

  function automatic logic in_window(input logic [31:0] a);
    return (a[31:5] == BASE[31:5]);
  endfunction

  function automatic exp_t model_outputs(input logic [31:0] a);
    exp_t e;
    logic [W-1:0] v;
    v     = '0;
    e.sel = in_window(a);
    if (e.sel) begin
      case ({a[4:2], 2'b00})
        5'h00:   v = m_stable;
        5'h04:   v = m_out;
        5'h10:   v = m_edge;
        5'h14:   v = m_en;
        default: v = '0;
      endcase
    end
    e.rdata = {{(32 - W){1'b0}}, v};
    e.out   = m_out;
    e.irq   = |(m_edge & m_en);
    return e;
  endfunction

  // A bit flips once the last DEFF synchronised samples all disagree with it.
  function automatic void model_step(input logic [31:0] a, input logic [31:0] wd, input logic w,
                                     input logic [W-1:0] p);
    logic [W-1:0] ns;
    logic [W-1:0] w1c;
    logic         all_diff;
    w1c = '0;
    m_hist.push_front(p);
    void'(m_hist.pop_back());
    ns = m_stable;
    for (int b = 0; b < int'(W); b++) begin
      all_diff = 1'b1;
      for (int k = 2; k < int'(DEFF) + 2; k++) begin
        if (m_hist[k][b] == m_stable[b]) all_diff = 1'b0;
      end
      if (all_diff) ns[b] = ~m_stable[b];
    end
    if (w && in_window(a)) begin
      case ({a[4:2], 2'b00})
        5'h04:   m_out = wd[W-1:0];
        5'h08:   m_out = m_out | wd[W-1:0];
        5'h0C:   m_out = m_out & ~wd[W-1:0];
        5'h10:   w1c = wd[W-1:0];
        5'h14:   m_en = wd[W-1:0];
        default: ;
      endcase
    end
    m_edge   = (m_edge & ~w1c) | (ns & ~m_stable);
    m_stable = ns;
  endfunction

  // One bus cycle: drive, queue the expected combinational outputs, advance the model.
  task automatic cycle(input logic r, input logic [31:0] a, input logic [31:0] wd, input logic w,
                       input logic [W-1:0] p);
    reset   = r;
    addr    = a;
    wdata   = wd;
    we      = w;
    in_pins = p;
    if (r) model_reset();
    exp_q.push_back(model_outputs(a));
    @(posedge clk);
    if (r) model_reset();
    else model_step(a, wd, w, p);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sel", 32'(sel), 32'(mon_e.sel));
      check("rdata", rdata, mon_e.rdata);
      check("out_pins", 32'(out_pins), 32'(mon_e.out));
      check("irq", 32'(irq), 32'(mon_e.irq));
    end
  end

  logic [31:0]  r_a, r_wd, seen;
  logic         r_w, r_r;
  logic [W-1:0] r_p;
  int           idx;

  initial begin
    reset   = 1'b1;
    addr    = '0;
    wdata   = '0;
    we      = 1'b0;
    in_pins = '0;
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b1, BASE + 32'h04, 32'h0, 1'b0, '0);
    cycle(1'b0, BASE + 32'h04, 32'h0, 1'b0, '0);

    // Set / clear
    cycle(1'b0, BASE + 32'h04, 32'hA5, 1'b1, '0);
    check("data_out_write", 32'(out_pins), 32'hA5);
    cycle(1'b0, BASE + 32'h08, 32'h0F, 1'b1, '0);
    check("out_set", 32'(out_pins), 32'hAF);
    cycle(1'b0, BASE + 32'h0C, 32'h81, 1'b1, '0);
    check("out_clr", 32'(out_pins), 32'h2E);
    cycle(1'b0, BASE + 32'h04, 32'h0, 1'b0, '0);
    check("data_out_read", rdata, 32'h2E);

    // Reset mid-debounce with the pin held high through release
    cycle(1'b0, BASE, 32'h0, 1'b0, 8'h01);
    cycle(1'b0, BASE, 32'h0, 1'b0, 8'h01);
    addr    = BASE + 32'h04;
    reset   = 1'b1;
    #1;
    check("rst_out_pins", 32'(out_pins), 32'h0);
    check("rst_rdata_804", rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    cycle(1'b1, BASE + 32'h04, 32'h0, 1'b0, 8'h01);
    cycle(1'b1, BASE + 32'h10, 32'h0, 1'b0, 8'h01);
    for (int i = 0; i < int'(LAT) - 1; i++) cycle(1'b0, BASE + 32'h10, 32'h0, 1'b0, 8'h01);
    check("edge_before_latency", rdata, 32'h0);
    cycle(1'b0, BASE + 32'h10, 32'h0, 1'b0, 8'h01);
    check("edge_after_reset_release", rdata, 32'h1);
    cycle(1'b0, BASE + 32'h10, 32'hFF, 1'b1, 8'h00);
    for (int i = 0; i < int'(LAT) + 2; i++) cycle(1'b0, BASE, 32'h0, 1'b0, 8'h00);

    // Glitch of three samples, then a sustained high
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, BASE, 32'h0, 1'b0, 8'h01);
      seen |= rdata;
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, BASE, 32'h0, 1'b0, 8'h00);
      seen |= rdata;
    end
    check("glitch_filtered", seen, (DEFF > 3) ? 32'h0 : 32'h1);
    for (int i = 0; i < int'(LAT) - 1; i++) cycle(1'b0, BASE, 32'h0, 1'b0, 8'h01);
    check("data_in_before_latency", rdata, 32'h0);
    cycle(1'b0, BASE, 32'h0, 1'b0, 8'h01);
    check("data_in_at_latency", rdata, 32'h1);

    // Edge flag and interrupt
    cycle(1'b0, BASE + 32'h10, 32'hFF, 1'b1, 8'h01);
    for (int i = 0; i < int'(LAT) + 1; i++) cycle(1'b0, BASE, 32'h0, 1'b0, 8'h00);
    cycle(1'b0, BASE + 32'h14, 32'h01, 1'b1, 8'h00);
    check("irq_idle", 32'(irq), 32'h0);
    for (int i = 0; i < int'(LAT); i++) cycle(1'b0, BASE + 32'h10, 32'h0, 1'b0, 8'h01);
    check("edge_set", rdata, 32'h1);
    check("irq_set", 32'(irq), 32'h1);
    cycle(1'b0, BASE + 32'h10, 32'h01, 1'b1, 8'h01);
    check("irq_cleared", 32'(irq), 32'h0);
    check("edge_cleared", rdata, 32'h0);

    // W1C on the same edge as a new rise
    for (int i = 0; i < int'(LAT) + 1; i++) cycle(1'b0, BASE, 32'h0, 1'b0, 8'h00);
    for (int i = 0; i < int'(LAT) - 1; i++) cycle(1'b0, BASE + 32'h10, 32'h0, 1'b0, 8'h01);
    cycle(1'b0, BASE + 32'h10, 32'h01, 1'b1, 8'h01);
    check("collision_edge", rdata, 32'h1);
    check("collision_irq", 32'(irq), 32'h1);

    // Decode boundaries
    cycle(1'b0, BASE + 32'h04, 32'h5A, 1'b1, 8'h01);
    addr  = 32'h7FC;
    wdata = 32'hFF;
    we    = 1'b1;
    #1;
    check("sel_7fc", 32'(sel), 32'h0);
    check("rdata_7fc", rdata, 32'h0);
    cycle(1'b0, 32'h7FC, 32'hFF, 1'b1, 8'h01);
    addr = 32'h820;
    #1;
    check("sel_820", 32'(sel), 32'h0);
    check("rdata_820", rdata, 32'h0);
    cycle(1'b0, 32'h820, 32'hFF, 1'b1, 8'h01);
    cycle(1'b0, 32'h824, 32'hFF, 1'b1, 8'h01);
    check("out_untouched", 32'(out_pins), 32'h5A);
    cycle(1'b0, BASE + 32'h18, 32'hFF, 1'b1, 8'h01);
    check("sel_818", 32'(sel), 32'h1);
    check("rdata_818", rdata, 32'h0);
    check("out_after_818", 32'(out_pins), 32'h5A);

    // Randomized traffic
    r_p = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx      = $urandom_range(0, W - 1);
        r_p[idx] = ~r_p[idx];
      end
      case ($urandom_range(0, 9))
        0:       r_a = $urandom();
        1:       r_a = ($urandom_range(0, 1) == 0) ? BASE - 32'h4 : BASE + 32'h20;
        default: r_a = BASE + 32'($urandom_range(0, 31));
      endcase
      r_wd = $urandom();
      r_w  = ($urandom_range(0, 3) == 0);
      r_r  = ($urandom_range(0, 499) == 0);
      cycle(r_r, r_a, r_wd, r_w, r_p);
    end

    cycle(1'b0, BASE, 32'h0, 1'b0, r_p);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
